// File: rtl/seq_counter.sv
// Step sequencer: IDLE/RUN counter that walks 0..LAST, with load, clear and optional auto-restart.
// Defining SEQ_COUNTER_DOWN_EN adds a dir input that selects a LAST..0 count-down sequence.
module seq_counter #(
  parameter int WIDTH        = 2,
  parameter int LAST         = 3,
  parameter int AUTO_RESTART = 0
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             sclr,
  input  logic             start,
  input  logic             en,
`ifdef SEQ_COUNTER_DOWN_EN
  input  logic             dir,
`endif
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);
  localparam logic [WIDTH-1:0] ZERO_V = WIDTH'(0);
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  state_t           state_r;
  logic [WIDTH-1:0] count_r;
  logic             busy_r;
  logic             done_r;
  logic             dn_s;
  logic             start_dn_s;
  logic [WIDTH-1:0] first_s;
  logic [WIDTH-1:0] start_first_s;
  logic [WIDTH-1:0] term_s;
  logic [WIDTH-1:0] clamp_s;
  logic             at_term_s;

`ifdef SEQ_COUNTER_DOWN_EN
  logic down_r;
  assign dn_s       = down_r;
  assign start_dn_s = dir;
`else
  assign dn_s       = 1'b0;
  assign start_dn_s = 1'b0;
`endif

  // First/terminal values depend on the direction latched for the running sequence.
  always_comb begin
    first_s       = dn_s ? LAST_V : ZERO_V;
    term_s        = dn_s ? ZERO_V : LAST_V;
    start_first_s = start_dn_s ? LAST_V : ZERO_V;
    if (load_val > LAST_V) begin
      clamp_s = LAST_V;
    end else begin
      clamp_s = load_val;
    end
    at_term_s = (count_r == term_s);
  end

  // Sequencer state, count and registered status; priority sclr > load > start > en.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_r <= IDLE;
      count_r <= ZERO_V;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef SEQ_COUNTER_DOWN_EN
      down_r  <= 1'b0;
`endif
    end else if (sclr) begin
      state_r <= IDLE;
      count_r <= ZERO_V;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (load) begin
      count_r <= clamp_s;
      done_r  <= 1'b0;
    end else if (start) begin
      state_r <= RUN;
      count_r <= start_first_s;
      busy_r  <= 1'b1;
      done_r  <= 1'b0;
`ifdef SEQ_COUNTER_DOWN_EN
      down_r  <= dir;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
        end
        RUN: begin
          if (!en) begin
            done_r <= 1'b0;
          end else if (at_term_s) begin
            done_r <= 1'b1;
            if (AUTO_RESTART != 0) begin
              count_r <= first_s;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            done_r  <= 1'b0;
            count_r <= dn_s ? (count_r - ONE_V) : (count_r + ONE_V);
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Terminal strobe only fires on an edge that will actually take the terminal step.
  assign tc = aclr_n & busy_r & en & at_term_s & ~sclr & ~load & ~start;

  assign count_out = count_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_seq_counter.sv
// Randomized bench for seq_counter: three parameterisations driven in parallel against an integer model.
module tb_seq_counter;

  logic       clk = 1'b0;
  logic       aclr_n, sclr, start, en, load;
  logic [2:0] lv;
`ifdef SEQ_COUNTER_DOWN_EN
  logic       dir;
`endif
  logic [1:0] cnt_a;
  logic [2:0] cnt_b, cnt_c;
  logic       busy_a, busy_b, busy_c, tc_a, tc_b, tc_c, done_a, done_b, done_c;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: instance 0 = (2,3,no wrap), 1 = (3,5,wrap), 2 = (3,0,no wrap)
  int lasts[3] = '{3, 5, 0};
  int autos[3] = '{0, 1, 0};
  int masks[3] = '{3, 7, 7};
  int m_cnt[3];
  bit m_run[3];
  bit m_done[3];
  bit m_dn[3];

  always #5 clk = ~clk;

  seq_counter #(.WIDTH(2), .LAST(3), .AUTO_RESTART(0)) u_a (
    .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .start(start), .en(en),
`ifdef SEQ_COUNTER_DOWN_EN
    .dir(dir),
`endif
    .load(load), .load_val(lv[1:0]), .count_out(cnt_a), .busy(busy_a), .tc(tc_a), .done(done_a));

  seq_counter #(.WIDTH(3), .LAST(5), .AUTO_RESTART(1)) u_b (
    .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .start(start), .en(en),
`ifdef SEQ_COUNTER_DOWN_EN
    .dir(dir),
`endif
    .load(load), .load_val(lv), .count_out(cnt_b), .busy(busy_b), .tc(tc_b), .done(done_b));

  seq_counter #(.WIDTH(3), .LAST(0), .AUTO_RESTART(0)) u_c (
    .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .start(start), .en(en),
`ifdef SEQ_COUNTER_DOWN_EN
    .dir(dir),
`endif
    .load(load), .load_val(lv), .count_out(cnt_c), .busy(busy_c), .tc(tc_c), .done(done_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dut_cnt(input int i);
    case (i)
      0:       return {30'd0, cnt_a};
      1:       return {29'd0, cnt_b};
      default: return {29'd0, cnt_c};
    endcase
  endfunction

  function automatic logic dut_busy(input int i);
    case (i)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic dut_tc(input int i);
    case (i)
      0:       return tc_a;
      1:       return tc_b;
      default: return tc_c;
    endcase
  endfunction

  function automatic logic dut_done(input int i);
    case (i)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic int term_of(input int i);
    return m_dn[i] ? 0 : lasts[i];
  endfunction

  function automatic bit model_tc(input int i);
    return m_run[i] && en && (m_cnt[i] == term_of(i)) && !sclr && !load && !start;
  endfunction

  task automatic check_outs(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_cnt%0d", tag, i), dut_cnt(i), m_cnt[i]);
      chk($sformatf("%s_busy%0d", tag, i), {31'd0, dut_busy(i)}, {31'd0, m_run[i]});
      chk($sformatf("%s_done%0d", tag, i), {31'd0, dut_done(i)}, {31'd0, m_done[i]});
    end
  endtask

  // One clock: drive at negedge, check tc, advance model, check registered outputs after the edge
  task automatic cycle(input bit s, input bit l, input bit st, input bit e, input bit d, input logic [2:0] v);
    bit dd;
    int lvi;
    @(negedge clk);
    sclr = s; load = l; start = st; en = e; lv = v;
`ifdef SEQ_COUNTER_DOWN_EN
    dir = d;
    dd  = d;
`else
    dd  = 1'b0;
`endif
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("tc%0d", i), {31'd0, dut_tc(i)}, {31'd0, model_tc(i)});
    end
    for (int i = 0; i < 3; i++) begin
      lvi = int'(v) & masks[i];
      if (s) begin
        m_cnt[i] = 0; m_run[i] = 1'b0; m_done[i] = 1'b0;
      end else if (l) begin
        m_cnt[i] = (lvi > lasts[i]) ? lasts[i] : lvi; m_done[i] = 1'b0;
      end else if (st) begin
        m_dn[i] = dd; m_cnt[i] = dd ? lasts[i] : 0; m_run[i] = 1'b1; m_done[i] = 1'b0;
      end else if (m_run[i] && e) begin
        if (m_cnt[i] == term_of(i)) begin
          m_done[i] = 1'b1;
          if (autos[i] != 0) m_cnt[i] = m_dn[i] ? lasts[i] : 0;
          else m_run[i] = 1'b0;
        end else begin
          m_done[i] = 1'b0;
          m_cnt[i]  = m_dn[i] ? m_cnt[i] - 1 : m_cnt[i] + 1;
        end
      end else begin
        m_done[i] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_outs("step");
  endtask

  // Asynchronous clear between edges: outputs must drop before any clock edge
  task automatic async_reset();
    @(negedge clk);
    sclr = 1'b0; load = 1'b0; start = 1'b0; en = 1'b1;
    #2 aclr_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_run[i] = 1'b0; m_done[i] = 1'b0;
      chk($sformatf("arst_tc%0d", i), {31'd0, dut_tc(i)}, 32'd0);
    end
    check_outs("arst");
    @(negedge clk);
    #2 aclr_n = 1'b1;
  endtask

  initial begin
    aclr_n = 1'b0; sclr = 1'b0; start = 1'b0; en = 1'b0; load = 1'b0; lv = 3'd0;
`ifdef SEQ_COUNTER_DOWN_EN
    dir = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_run[i] = 1'b0; m_done[i] = 1'b0; m_dn[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset");
    en = 1'b1;
    #1;
    chk("reset_tc_a", {31'd0, tc_a}, 32'd0);
    en = 1'b0;
    @(negedge clk);
    aclr_n = 1'b1;

    // Full sequence, then hold at LAST with no further activity
    cycle(0, 0, 1, 0, 0, 3'd0);
    repeat (7) cycle(0, 0, 0, 1, 0, 3'd0);
    chk("a_hold_cnt", {30'd0, cnt_a}, 32'd3);
    chk("a_hold_busy", {31'd0, busy_a}, 32'd0);

    // Load clamp, then sclr beating load and start
    cycle(0, 0, 1, 0, 0, 3'd0);
    cycle(0, 0, 0, 1, 0, 3'd0);
    cycle(0, 1, 0, 0, 0, 3'd7);
    chk("b_load_clamp", {29'd0, cnt_b}, 32'd5);
    cycle(1, 1, 1, 1, 0, 3'd7);

    // en gaps, then restart from mid-sequence
    cycle(0, 0, 1, 0, 0, 3'd0);
    cycle(0, 0, 0, 1, 0, 3'd0);
    cycle(0, 0, 0, 0, 0, 3'd0);
    cycle(0, 0, 0, 0, 0, 3'd0);
    cycle(0, 0, 0, 1, 0, 3'd0);
    cycle(0, 0, 1, 1, 0, 3'd0);
    repeat (4) cycle(0, 0, 0, 1, 0, 3'd0);

    // Direction sampled at start only
    cycle(0, 0, 1, 0, 1, 3'd0);
    repeat (6) cycle(0, 0, 0, 1, 0, 3'd0);

    // Abort mid-run via aclr_n
    cycle(0, 0, 1, 0, 0, 3'd0);
    cycle(0, 0, 0, 1, 0, 3'd0);
    async_reset();
    repeat (4) cycle(0, 0, 0, 1, 0, 3'd0);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
      end else begin
        cycle($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_counter.md
SEQ_COUNTER -- requirements
Module: seq_counter

Interface
REQ-001 Parameter WIDTH, default 2: count register width, legal 1..16.
REQ-002 Parameter LAST, default 3: final count of a sequence, legal 0..2^WIDTH-1.
REQ-003 Parameter AUTO_RESTART, default 0: 1 = wrap LAST->0 and stay running; 0 = stop after LAST.
REQ-004 Port: clk, input, 1, single clock, all state updates on its rising edge.
REQ-005 Port: aclr_n, input, 1, asynchronous active-low reset.
REQ-006 Port: sclr, input, 1, synchronous clear.
REQ-007 Port: start, input, 1, begin a sequence.
REQ-008 Port: en, input, 1, advance one step.
REQ-009 Port: load, input, 1, synchronous load.
REQ-010 Port: load_val, input, WIDTH, value for load.
REQ-011 Port: count_out, output, WIDTH, registered current step.
REQ-012 Port: busy, output, 1, registered, high while in RUN.
REQ-013 Port: tc, output, 1, combinational terminal-count strobe.
REQ-014 Port: done, output, 1, registered one-cycle end-of-sequence pulse.

Function
REQ-015 FSM states IDLE and RUN; busy SHALL equal (state==RUN).
REQ-016 Per-edge priority SHALL be sclr > load > start > en.
REQ-017 sclr=1: count_out=0, state IDLE, done=0 next cycle.
REQ-018 load=1: count_out=min(load_val,LAST); state unchanged; done=0.
REQ-019 IDLE, start=1: count_out=0 (first step value), state RUN; en ignored that cycle.
REQ-020 IDLE, start=0: count_out holds; en has no effect.
REQ-021 RUN, en=1, count_out<LAST: count_out increments by 1.
REQ-022 RUN, en=1, count_out==LAST, AUTO_RESTART=0: count_out holds LAST, state IDLE, done=1 for exactly the next cycle.
REQ-023 RUN, en=1, count_out==LAST, AUTO_RESTART=1: count_out=0, state stays RUN, done=1 for the next cycle.
REQ-024 RUN, en=0: count_out and state hold; done=0.
REQ-025 RUN, start=1: count_out=0, state RUN (restart); done not asserted.
REQ-026 tc SHALL equal busy & en & (count_out==LAST) & ~sclr & ~load & ~start.
REQ-027 LAST=0: start then first en SHALL assert tc and complete the sequence (one-step sequence).
REQ-028 Arithmetic SHALL never exceed LAST; count_out never holds a value above LAST.
REQ-029 Sequence latency: start at edge k, en held high -> done high in cycle k+LAST+2.

Reset
REQ-030 aclr_n=0 SHALL immediately, independent of clk, force count_out=0, state IDLE, busy=0, done=0.
REQ-031 tc SHALL be 0 while aclr_n=0.
REQ-032 Release of aclr_n SHALL take effect from the first rising clk after deassertion; reset mid-sequence aborts with no done pulse.

Configuration
REQ-033 Macro SEQ_COUNTER_DOWN_EN SHALL, when defined, add input port dir (1 bit, after en).
REQ-034 With SEQ_COUNTER_DOWN_EN and dir=1: start loads LAST, en decrements, terminal value is 0 (tc, done, wrap-to-LAST apply at 0); dir sampled at start and held for the sequence.
REQ-035 Without SEQ_COUNTER_DOWN_EN: no dir port, counting up only as in REQ-019..REQ-023.

Verification
REQ-036 aclr_n=0 mid-RUN between edges -> count_out=0, busy=0 immediately, no done after release.
REQ-037 WIDTH=2, LAST=3, AUTO_RESTART=0: start, en=1 continuous -> count_out 0,1,2,3; tc high at 3; done one cycle; busy drops; count_out holds 3.
REQ-038 AUTO_RESTART=1, LAST=2: en=1 continuous -> 0,1,2,0,1,2; done pulses each wrap; busy stays 1.
REQ-039 RUN at count 1: load=1, load_val=7, WIDTH=3, LAST=5 -> count_out=5; same cycle start=1 and sclr=1 -> count_out=0, IDLE.
REQ-040 en toggled 1,0,0,1 in RUN -> count advances only on en=1 edges; start at count 2 -> restart to 0, no done.
REQ-041 SEQ_COUNTER_DOWN_EN defined, dir=1, LAST=3: start, en=1 -> 3,2,1,0; tc at 0; done one cycle.
